// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the execute stage and the PC generator.
// The execute stage drives redirects and BTB training; pc_gen returns the fetch PC and prediction.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Redirect beats stall, stall beats prediction, prediction beats sequential fetch.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] r_pc;
  logic            r_valid  [BTB_DEPTH];
  logic [TAGW-1:0] r_tag    [BTB_DEPTH];
  logic [XLEN-1:0] r_target [BTB_DEPTH];
  logic [1:0]      r_ctr    [BTB_DEPTH];

  logic [IDX-1:0]  w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic            w_lk_hit;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;
  logic [XLEN-1:0] w_pc_raw;
  logic [XLEN-1:0] w_pc_nxt;
  logic [IDX-1:0]  w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic            w_up_hit;
  logic [1:0]      w_up_ctr;
  logic [1:0]      w_ctr_nxt;
  logic            w_unused;

  // Lookup reads registered BTB state only, so a same-cycle update is not bypassed.
  assign w_lk_idx      = r_pc[IDX+1:2];
  assign w_lk_tag      = r_pc[XLEN-1:IDX+2];
  assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_pred_target = w_pred_taken ? r_target[w_lk_idx] : '0;

  always_comb begin
    w_pc_raw = r_pc + XLEN'(4);
    if (bus.redirect_valid) begin
      w_pc_raw = bus.redirect_pc;
    end else if (bus.stall) begin
      w_pc_raw = r_pc;
    end else if (w_pred_taken) begin
      w_pc_raw = w_pred_target;
    end
  end

  assign w_pc_nxt = w_pc_raw & ~XLEN'(3);

  assign w_up_idx = bus.upd_pc[IDX+1:2];
  assign w_up_tag = bus.upd_pc[XLEN-1:IDX+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_nxt = w_up_ctr;
    if (bus.upd_taken) begin
      if (w_up_ctr != 2'b11) w_ctr_nxt = w_up_ctr + 2'd1;
    end else begin
      if (w_up_ctr != 2'b00) w_ctr_nxt = w_up_ctr - 2'd1;
    end
  end

  assign w_unused = ^bus.upd_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC & ~XLEN'(3);
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else begin
      r_pc <= w_pc_nxt;
      if (bus.upd_valid) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_ctr_nxt;
          if (bus.upd_taken) r_target[w_up_idx] <= bus.upd_target;
        end else if (bus.upd_taken) begin
          // Allocation evicts whatever aliased entry sat at this index.
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= bus.upd_target;
          r_ctr[w_up_idx]    <= 2'b10;
        end
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus queues the expected pc/prediction per cycle,
// a negedge monitor pops and compares whatever is due in the current cycle.
module tb_pc_gen;
  logic clk;
  logic rst;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_sample: cycle %0d not sampled, now %0d", mon_e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      cmp($sformatf("pc@%0d", cyc), bus.pc, mon_e.pc);
      cmp($sformatf("pred_taken@%0d", cyc), {31'b0, bus.pred_taken}, {31'b0, mon_e.pt});
      cmp($sformatf("pred_target@%0d", cyc), bus.pred_target, mon_e.tgt);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_now(input logic [31:0] p, input logic t, input logic [31:0] g);
    exp_t e;
    e.cyc = cyc;
    e.pc  = p;
    e.pt  = t;
    e.tgt = g;
    exp_q.push_back(e);
  endtask

  task automatic drv(input logic st, input logic rv, input logic [31:0] rpc);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic upd(input logic v, input logic [31:0] p, input logic [31:0] tg, input logic tk);
    bus.upd_valid  = v;
    bus.upd_pc     = p;
    bus.upd_target = tg;
    bus.upd_taken  = tk;
  endtask

  initial begin
    rst = 1'b0;
    // Activity during reset must be ignored.
    drv(1'b0, 1'b1, 32'h500);
    upd(1'b1, 32'h0, 32'h40, 1'b1);
    repeat (2) next();
    exp_now(32'h0, 1'b0, 32'h0);
    next();
    drv(1'b0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    exp_now(32'h0, 1'b0, 32'h0);
    next(); exp_now(32'h4, 1'b0, 32'h0);
    next(); exp_now(32'h8, 1'b0, 32'h0);
    next(); exp_now(32'hC, 1'b0, 32'h0);

    // Redirect overrides stall; then stall holds.
    drv(1'b1, 1'b1, 32'h103);
    next(); exp_now(32'h100, 1'b0, 32'h0);
    drv(1'b1, 1'b0, 32'h0);
    next(); exp_now(32'h100, 1'b0, 32'h0);
    next(); exp_now(32'h100, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'h0);
    next(); exp_now(32'h104, 1'b0, 32'h0);

    // Allocate 0x10 -> 0x80 alongside a redirect, then follow the prediction.
    drv(1'b0, 1'b1, 32'h8);
    upd(1'b1, 32'h10, 32'h80, 1'b1);
    next(); exp_now(32'h8, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    next(); exp_now(32'hC, 1'b0, 32'h0);
    next(); exp_now(32'h10, 1'b1, 32'h80);
    next(); exp_now(32'h80, 1'b0, 32'h0);
    next(); exp_now(32'h84, 1'b0, 32'h0);

    // Update while stalled on the same PC: old contents this cycle, new next cycle.
    drv(1'b1, 1'b1, 32'h30);
    next(); exp_now(32'h30, 1'b0, 32'h0);
    drv(1'b1, 1'b0, 32'h0);
    upd(1'b1, 32'h30, 32'h300, 1'b1);
    next(); exp_now(32'h30, 1'b1, 32'h300);
    drv(1'b0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    next(); exp_now(32'h300, 1'b0, 32'h0);

    // Counter training on 0x10 (starts at 10).
    drv(1'b1, 1'b1, 32'h10);
    upd(1'b1, 32'h10, 32'h80, 1'b1);
    next(); exp_now(32'h10, 1'b1, 32'h80);
    drv(1'b1, 1'b0, 32'h0);
    next(); exp_now(32'h10, 1'b1, 32'h80);
    upd(1'b1, 32'h10, 32'h444, 1'b0);
    next(); exp_now(32'h10, 1'b1, 32'h80);
    next(); exp_now(32'h10, 1'b0, 32'h0);
    next(); exp_now(32'h10, 1'b0, 32'h0);
    next(); exp_now(32'h10, 1'b0, 32'h0);
    upd(1'b1, 32'h10, 32'h80, 1'b1);
    next(); exp_now(32'h10, 1'b0, 32'h0);
    upd(1'b1, 32'h10, 32'h88, 1'b1);
    next(); exp_now(32'h10, 1'b1, 32'h88);

    // Aliasing at index 4: not-taken miss is ignored, taken miss replaces.
    upd(1'b1, 32'h50, 32'h500, 1'b0);
    next(); exp_now(32'h10, 1'b1, 32'h88);
    upd(1'b1, 32'h50, 32'h200, 1'b1);
    next(); exp_now(32'h10, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    drv(1'b1, 1'b1, 32'h50);
    next(); exp_now(32'h50, 1'b1, 32'h200);
    upd(1'b1, 32'h50, 32'h200, 1'b0);
    drv(1'b1, 1'b0, 32'h0);
    next(); exp_now(32'h50, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    drv(1'b0, 1'b0, 32'h0);
    next(); exp_now(32'h54, 1'b0, 32'h0);

    // Wrap at the top of the address space, then prediction at 0x8.
    drv(1'b0, 1'b1, 32'hFFFF_FFFC);
    next(); exp_now(32'hFFFF_FFFC, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'h0);
    upd(1'b1, 32'h8, 32'h40, 1'b1);
    next(); exp_now(32'h0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    next(); exp_now(32'h4, 1'b0, 32'h0);
    next(); exp_now(32'h8, 1'b1, 32'h40);
    next(); exp_now(32'h40, 1'b0, 32'h0);

    // Asynchronous reset between edges, with a pending stall+redirect.
    #6;
    drv(1'b1, 1'b1, 32'h700);
    #1 rst = 1'b0;
    #1;
    cmp("async_rst_pc", bus.pc, 32'h0);
    cmp("async_rst_pred_taken", {31'b0, bus.pred_taken}, 32'h0);
    cmp("async_rst_pred_target", bus.pred_target, 32'h0);
    next();
    drv(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    exp_now(32'h0, 1'b0, 32'h0);
    next(); exp_now(32'h4, 1'b0, 32'h0);
    next(); exp_now(32'h8, 1'b0, 32'h0);

    next();
    next();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, address/PC width in bits.
REQ-002 Parameter BTB_DEPTH, default 16, branch-target-buffer entries; power of two, >= 2; IDX = log2(BTB_DEPTH).
REQ-003 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, regardless of clk.
REQ-006 stall  input  1  high = hold current PC.
REQ-007 redirect_valid  input  1  execute-stage redirect (mispredict, jal/jalr resolution).
REQ-008 redirect_pc  input  XLEN  redirect target.
REQ-009 upd_valid  input  1  BTB training request from execute.
REQ-010 upd_pc  input  XLEN  PC of resolved branch/jump.
REQ-011 upd_target  input  XLEN  resolved taken target.
REQ-012 upd_taken  input  1  resolved direction.
REQ-013 pc  output  XLEN  registered current fetch PC.
REQ-014 pred_taken  output  1  combinational prediction for pc.
REQ-015 pred_target  output  XLEN  combinational predicted target for pc; 0 when pred_taken low.

Function
REQ-016 BTB entry SHALL hold valid, tag = addr[XLEN-1:IDX+2], target[XLEN-1:0], 2-bit counter ctr; index = addr[IDX+1:2].
REQ-017 Lookup SHALL be hit = valid & tag match on pc; pred_taken = hit & ctr[1]; pred_target = entry target.
REQ-018 Next PC priority, evaluated each edge: redirect_valid -> redirect_pc; else stall -> hold pc; else pred_taken -> pred_target; else pc + 4.
REQ-019 redirect_valid SHALL override stall in the same cycle.
REQ-020 Every value loaded into pc SHALL have bits [1:0] forced to 0 (misalignment fault handled elsewhere).
REQ-021 pc + 4 SHALL wrap modulo 2^XLEN (all-ones-aligned 0xFFFFFFFC -> 0x00000000 at XLEN=32).
REQ-022 Update on upd_valid at rising edge, indexed by upd_pc: hit -> ctr saturating +1 if upd_taken else saturating -1; target <= upd_target only if upd_taken.
REQ-023 Update miss with upd_taken=1 SHALL allocate: valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken), replacing any entry at that index.
REQ-024 Update miss with upd_taken=0 SHALL leave the BTB unchanged.
REQ-025 ctr SHALL saturate at 2'b11 and 2'b00; no wrap.
REQ-026 Lookup in the update cycle SHALL return pre-update contents (no bypass); new contents visible the following cycle.
REQ-027 BTB update SHALL proceed independently of stall and redirect_valid.
REQ-028 Latency: redirect or prediction applied to pc one clock after sampling; pred outputs valid same cycle as pc.

Reset
REQ-029 rst low SHALL asynchronously set pc = RESET_PC (bits [1:0] cleared), all valid = 0, all ctr = 2'b00, all tag/target = 0; pred_taken = 0, pred_target = 0.
REQ-030 Inputs SHALL be ignored while rst is low; first update occurs on first rising edge after rst deasserts.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation.

Verification
REQ-032 Reset release, no stall, no redirect, 4 clocks -> pc sequence 0x0, 0x4, 0x8, 0xC, pred_taken = 0 throughout.
REQ-033 stall=1 and redirect_valid=1, redirect_pc=0x103 same cycle -> next pc = 0x100; stall alone next cycle -> pc holds 0x100.
REQ-034 upd_valid, upd_pc=0x10, upd_target=0x80, upd_taken=1; later pc reaches 0x10 -> pred_taken=1, pred_target=0x80, next pc=0x80.
REQ-035 Train entry 0x10 taken twice (ctr=11), then not-taken three times -> ctr 10, 01, 00; pred_taken=0 after second not-taken; extra not-taken keeps ctr=00.
REQ-036 Aliasing: allocate 0x10 taken, then allocate 0x10 + 4*BTB_DEPTH taken target 0x200 -> lookup at 0x10 misses, at alias hits with 0x200.
REQ-037 pc=0xFFFFFFFC, no prediction -> next pc=0x00000000; rst pulsed low between edges -> pc=RESET_PC immediately, BTB hits cleared.
